// File: rtl/lmsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_pkg
//  Purpose  : Shared types and constants for the LM/SM transfer sequencer.
//             - Default widths for the address, mask and register index.
//             - State encoding used by the sequencer FSM.
//             - LM/SM opcode values the main control FSM drives onto is_store.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lmsm_pkg;

  localparam int c_ADDR_W = 16;  // memory word-address width
  localparam int c_NREG   = 8;   // mask width / number of registers
  localparam int c_IDX_W  = 3;   // clog2(c_NREG)

  // Values for is_store as seen by the main control FSM.
  localparam logic c_OP_LM = 1'b0;  // load-multiple: memory read, RF write
  localparam logic c_OP_SM = 1'b1;  // store-multiple: RF read, memory write

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } lmsm_state_t;

endpackage : lmsm_pkg
`default_nettype wire

// File: rtl/lmsm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_sequencer_if
//  Purpose  : Bundles the control handshake and the memory / register-file
//             sequencing signals of the LM/SM sequencer.
//  Signals  : start, is_store, mask, base_addr  - request from main control
//             mem_ack                           - memory completion
//             mem_req, mem_we, mem_addr         - memory access
//             reg_idx, rf_we                    - register-file side
//             busy, done, xfer_cnt              - status
//  Modports : master - the environment (control FSM + memory)
//             slave  - the sequencer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8,
  parameter int IDX_W  = 3
);

  logic              start;
  logic              is_store;
  logic [NREG-1:0]   mask;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [IDX_W-1:0]  reg_idx;
  logic              rf_we;
  logic              busy;
  logic              done;
  logic [IDX_W:0]    xfer_cnt;

  modport master (
    output start, is_store, mask, base_addr, mem_ack,
    input  mem_req, mem_we, mem_addr, reg_idx, rf_we, busy, done, xfer_cnt
  );

  modport slave (
    input  start, is_store, mask, base_addr, mem_ack,
    output mem_req, mem_we, mem_addr, reg_idx, rf_we, busy, done, xfer_cnt
  );

endinterface : lmsm_sequencer_if
`default_nettype wire

// File: rtl/lmsm_pick.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_pick
//  Purpose  : Combinational lowest-set-bit priority picker.
//  Ports    : i_mask [NREG-1:0]  - candidate bits
//             o_idx  [IDX_W-1:0] - index of the lowest set bit (0 if none)
//             o_any              - at least one bit of i_mask is set
//  Revision : 1.0 - initial release
// ============================================================================
module lmsm_pick #(
  parameter int NREG  = 8,
  parameter int IDX_W = 3
) (
  input  wire logic [NREG-1:0]  i_mask,
  output logic      [IDX_W-1:0] o_idx,
  output logic                  o_any
);

  // Scan from the top down so that the lowest set bit is the last writer.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule : lmsm_pick
`default_nettype wire

// File: rtl/lmsm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lmsm_sequencer
//  Purpose  : Multi-cycle controller for load-multiple / store-multiple.
//             Walks the set bits of a captured register mask, lowest index
//             first, issuing one memory access per register at consecutive
//             word addresses starting at the captured base address.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - lmsm_sequencer_if.slave (request, memory, RF, status)
//  Revision : 1.0 - initial release
// ============================================================================
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int NREG   = c_NREG,
  parameter int IDX_W  = c_IDX_W
) (
  input wire logic          clk,
  input wire logic          rst_n,
  lmsm_sequencer_if.slave   bus
);

  lmsm_state_t       r_state;
  lmsm_state_t       w_next;
  logic [NREG-1:0]   r_mask;
  logic              r_store;
  logic [ADDR_W-1:0] r_addr;
  logic [IDX_W:0]    r_cnt;
  logic [IDX_W-1:0]  r_idx;   // last transferred index, shown outside XFER

  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic [NREG-1:0]   w_mask_clr;
  logic              w_ack;

  lmsm_pick #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_mask (r_mask),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_mask_clr = r_mask & ~(NREG'(1) << w_idx);
  assign w_ack      = (r_state == ST_XFER) && bus.mem_ack;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next = (bus.mask != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        // An empty mask cannot reach XFER; the !w_any term only guards
        // against being stranded here with nothing left to transfer.
        if (!w_any || (bus.mem_ack && (w_mask_clr == '0))) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_store <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && bus.start) begin
        r_mask  <= bus.mask;
        r_store <= bus.is_store;
        r_addr  <= bus.base_addr;
        r_cnt   <= '0;
      end else if (w_ack) begin
        r_mask  <= w_mask_clr;
        r_addr  <= r_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        r_cnt   <= r_cnt + (IDX_W + 1)'(1);
        r_idx   <= w_idx;
      end
    end
  end

  assign bus.mem_req  = (r_state == ST_XFER);
  assign bus.mem_we   = (r_state == ST_XFER) && r_store;
  assign bus.mem_addr = r_addr;
  assign bus.reg_idx  = (r_state == ST_XFER) ? w_idx : r_idx;
  assign bus.rf_we    = w_ack && !r_store;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.xfer_cnt = r_cnt;

endmodule : lmsm_sequencer
`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lmsm_sequencer
//  Purpose  : Directed self-checking bench for lmsm_sequencer.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lmsm_sequencer;
  import lmsm_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  lmsm_sequencer_if #(.ADDR_W(16), .NREG(8), .IDX_W(3)) u_if ();

  lmsm_sequencer #(.ADDR_W(16), .NREG(8), .IDX_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives start for one cycle; on return the bench sits in cycle 1.
  task automatic kick(input logic st, input logic [7:0] m, input logic [15:0] b);
    u_if.start     = 1'b1;
    u_if.is_store  = st;
    u_if.mask      = m;
    u_if.base_addr = b;
    @(negedge clk);
    u_if.start     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  32'(u_if.mem_req),  32'd0);
    chk({tag, "_we"},   32'(u_if.mem_we),   32'd0);
    chk({tag, "_addr"}, 32'(u_if.mem_addr), 32'd0);
    chk({tag, "_idx"},  32'(u_if.reg_idx),  32'd0);
    chk({tag, "_rfwe"}, 32'(u_if.rf_we),    32'd0);
    chk({tag, "_busy"}, 32'(u_if.busy),     32'd0);
    chk({tag, "_done"}, 32'(u_if.done),     32'd0);
    chk({tag, "_cnt"},  32'(u_if.xfer_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_addr;
    int          n_done;

    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    u_if.start     = 1'b0;
    u_if.is_store  = 1'b0;
    u_if.mask      = '0;
    u_if.base_addr = '0;
    u_if.mem_ack   = 1'b0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ---- LM mask 0x81 base 0x0040, ack tied high ----
    u_if.mem_ack = 1'b1;
    kick(c_OP_LM, 8'h81, 16'h0040);
    chk("t1c1_req",  32'(u_if.mem_req),  32'd1);
    chk("t1c1_idx",  32'(u_if.reg_idx),  32'd0);
    chk("t1c1_addr", 32'(u_if.mem_addr), 32'h0040);
    chk("t1c1_rfwe", 32'(u_if.rf_we),    32'd1);
    chk("t1c1_we",   32'(u_if.mem_we),   32'd0);
    @(negedge clk);
    chk("t1c2_idx",  32'(u_if.reg_idx),  32'd7);
    chk("t1c2_addr", 32'(u_if.mem_addr), 32'h0041);
    chk("t1c2_rfwe", 32'(u_if.rf_we),    32'd1);
    @(negedge clk);
    chk("t1c3_done", 32'(u_if.done),     32'd1);
    chk("t1c3_busy", 32'(u_if.busy),     32'd1);
    chk("t1c3_req",  32'(u_if.mem_req),  32'd0);
    chk("t1c3_rfwe", 32'(u_if.rf_we),    32'd0);
    chk("t1c3_cnt",  32'(u_if.xfer_cnt), 32'd2);
    @(negedge clk);
    chk("t1c4_busy", 32'(u_if.busy),     32'd0);
    chk("t1c4_done", 32'(u_if.done),     32'd0);
    chk("t1c4_idx",  32'(u_if.reg_idx),  32'd7);

    // ---- empty mask: straight to DONE ----
    kick(c_OP_LM, 8'h00, 16'h1234);
    chk("t2c1_done", 32'(u_if.done),     32'd1);
    chk("t2c1_req",  32'(u_if.mem_req),  32'd0);
    chk("t2c1_cnt",  32'(u_if.xfer_cnt), 32'd0);
    @(negedge clk);
    chk("t2c2_busy", 32'(u_if.busy),     32'd0);
    chk("t2c2_req",  32'(u_if.mem_req),  32'd0);

    // ---- SM mask 0x06 base 0x1000, two wait states per access ----
    u_if.mem_ack = 1'b0;
    kick(c_OP_SM, 8'h06, 16'h1000);
    for (int k = 1; k <= 6; k++) begin
      u_if.mem_ack = (k % 3 == 0);
      chk($sformatf("t3c%0d_req", k),  32'(u_if.mem_req),  32'd1);
      chk($sformatf("t3c%0d_we", k),   32'(u_if.mem_we),   32'd1);
      chk($sformatf("t3c%0d_rfwe", k), 32'(u_if.rf_we),    32'd0);
      chk($sformatf("t3c%0d_idx", k),  32'(u_if.reg_idx),  (k <= 3) ? 32'd1 : 32'd2);
      chk($sformatf("t3c%0d_addr", k), 32'(u_if.mem_addr), (k <= 3) ? 32'h1000 : 32'h1001);
      @(negedge clk);
    end
    u_if.mem_ack = 1'b0;
    chk("t3c7_done", 32'(u_if.done),     32'd1);
    chk("t3c7_cnt",  32'(u_if.xfer_cnt), 32'd2);
    chk("t3c7_rfwe", 32'(u_if.rf_we),    32'd0);
    @(negedge clk);
    chk("t3c8_busy", 32'(u_if.busy),     32'd0);

    // ---- LM mask 0xFF base 0xFFFE: address wrap ----
    u_if.mem_ack = 1'b1;
    kick(c_OP_LM, 8'hFF, 16'hFFFE);
    exp_addr = 16'hFFFE;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4x%0d_idx", k),  32'(u_if.reg_idx),  32'(k));
      chk($sformatf("t4x%0d_addr", k), 32'(u_if.mem_addr), 32'(exp_addr));
      chk($sformatf("t4x%0d_cnt", k),  32'(u_if.xfer_cnt), 32'(k));
      exp_addr = exp_addr + 16'd1;
      @(negedge clk);
    end
    chk("t4_done", 32'(u_if.done),     32'd1);
    chk("t4_cnt",  32'(u_if.xfer_cnt), 32'd8);
    @(negedge clk);
    chk("t4_busy", 32'(u_if.busy),     32'd0);

    // ---- start while busy is ignored ----
    kick(c_OP_LM, 8'h03, 16'h0200);
    n_done = 0;
    u_if.start     = 1'b1;
    u_if.is_store  = c_OP_SM;
    u_if.mask      = 8'h01;
    u_if.base_addr = 16'h5555;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("t5c2_idx",  32'(u_if.reg_idx),  32'd1);
    chk("t5c2_addr", 32'(u_if.mem_addr), 32'h0201);
    chk("t5c2_we",   32'(u_if.mem_we),   32'd0);
    chk("t5c2_rfwe", 32'(u_if.rf_we),    32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (u_if.done) n_done++;
    end
    chk("t5_ndone", 32'(n_done),      32'd1);
    chk("t5_cnt",   32'(u_if.xfer_cnt), 32'd2);
    chk("t5_busy",  32'(u_if.busy),     32'd0);

    // ---- reset during the second transfer of mask 0x0F ----
    kick(c_OP_LM, 8'h0F, 16'h0300);
    chk("t6c1_idx", 32'(u_if.reg_idx), 32'd0);
    @(negedge clk);
    chk("t6c2_idx", 32'(u_if.reg_idx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6rst");
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (u_if.done) n_done++;
    end
    chk("t6_ndone", 32'(n_done),     32'd0);
    chk("t6_busy",  32'(u_if.busy),  32'd0);
    kick(c_OP_SM, 8'h08, 16'h0777);
    chk("t6n_idx",  32'(u_if.reg_idx),  32'd3);
    chk("t6n_addr", 32'(u_if.mem_addr), 32'h0777);
    chk("t6n_we",   32'(u_if.mem_we),   32'd1);
    chk("t6n_rfwe", 32'(u_if.rf_we),    32'd0);
    @(negedge clk);
    chk("t6n_done", 32'(u_if.done),     32'd1);
    chk("t6n_cnt",  32'(u_if.xfer_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_lmsm_sequencer
`default_nettype wire

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Multi-cycle controller for the load-multiple (LM) and store-multiple (SM) instructions. It takes an 8-bit register mask and a base address. It then walks the set bits of the mask one per memory transfer, lowest register index first. For each transfer it drives the register index and an incrementing word address into the memory and register-file datapath. It sits between the main control FSM, which raises start, and the memory and register-file ports, which it sequences directly.

Parameters:
ADDR_W, 16, memory word-address width
NREG, 8, mask width / number of architectural registers
IDX_W, 3, register index width (clog2 of NREG)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin an LM/SM; sampled only in IDLE
is_store  in  1  1 = SM (memory write), 0 = LM (memory read); captured with start
mask  in  NREG  register list; bit i selects Ri; captured with start
base_addr  in  ADDR_W  address of the first transfer; captured with start
mem_ack  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write (SM); valid while mem_req
mem_addr  out  ADDR_W  word address of the current access
reg_idx  out  IDX_W  register index of the current transfer (RF read port for SM, RF write index for LM)
rf_we  out  1  register-file write strobe for LM data (combinational)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the sequence completes
xfer_cnt  out  IDX_W+1  number of completed transfers in the current or last sequence

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, reg_idx=0, rf_we=0, busy=0, done=0, xfer_cnt=0.
  - Internal mask_q, store_q and addr_q are cleared.
  - Deassertion mid-sequence abandons the sequence; no done pulse is issued.
- States: IDLE, XFER, DONE.
- IDLE:
  - start=1: capture mask->mask_q, is_store->store_q, base_addr->addr_q; clear xfer_cnt.
  - Then go to XFER if mask != 0, else go to DONE (zero memory accesses).
  - start=0: stay in IDLE.
- XFER:
  - mem_req=1, mem_we=store_q, mem_addr=addr_q.
  - reg_idx = index of the lowest set bit of mask_q.
  - All of these stay stable until mem_ack.
  - mem_ack=1 in XFER:
    - rf_we = !store_q in the same cycle.
    - Clear bit reg_idx in mask_q; addr_q <= addr_q+1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000); xfer_cnt += 1.
    - If the updated mask_q is 0, go to DONE; otherwise stay in XFER for the next register.
  - mem_ack may arrive in the same cycle mem_req first rises (zero wait state). An ack lasting several cycles counts once per cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- mem_ack outside XFER is ignored. start outside IDLE is ignored (no queueing).
- rf_we is 0 whenever state != XFER, or mem_ack=0, or store_q=1.
- Latency:
  - start is sampled at edge 0; mem_req is high from cycle 1.
  - With N set bits and zero wait states, done is high in cycle N+1 and busy falls in cycle N+2.
  - Each wait state adds one cycle.
- Only the captured copies are used after start; changes on mask, is_store or base_addr during busy have no effect.
- reg_idx holds its last value in IDLE/DONE; mem_addr holds addr_q.

Decomposition:
- Shared package (lmsm_pkg): state encoding constants (IDLE, XFER, DONE), ADDR_W, NREG, IDX_W defaults, and the LM/SM opcode constants used by the main control FSM to drive is_store.
- One natural sub-module: lmsm_pick. It is a combinational lowest-set-bit priority picker, mask_q[NREG-1:0] -> idx[IDX_W-1:0] plus any_set. It is kept separate from the existing highest-first encoder so both can be verified independently.
- Everything else stays in the FSM body.

Test Plan:
- LM, mask=0x81, base=0x0040, mem_ack tied 1 -> cycle1: reg_idx=0, addr=0x0040, rf_we=1. Cycle2: reg_idx=7, addr=0x0041, rf_we=1. Cycle3: done=1, xfer_cnt=2. Cycle4: busy=0.
- mask=0x00, start -> done=1 in cycle1; mem_req never asserted; xfer_cnt=0.
- SM, mask=0x06, base=0x1000, two wait states per access -> reg_idx=1 held 3 cycles at 0x1000 with mem_we=1, then reg_idx=2 at 0x1001; rf_we never 1; done in cycle 7.
- LM, mask=0xFF, base=0xFFFE, ack every cycle -> addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x0005; reg_idx 0..7 in order; xfer_cnt=8.
- start pulsed again while busy with mask=0x01 -> ignored; the original sequence completes unchanged; exactly one done.
- rst_n low during the second transfer of mask=0x0F -> all outputs 0 immediately; no done; a new start after release runs a fresh sequence from its own base_addr.
